// File: rtl/pulse_burst_tx_pkg.sv
// Shared types and helpers for the pulse burst transmitter.
// PULSE_BURST_TX_RAMP_EN selects the shaped pulse, which moves the peak beat to k=1.
package pulse_burst_tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } state_e;

`ifdef PULSE_BURST_TX_RAMP_EN
    localparam int unsigned PEAK_IDX = 1;
`else
    localparam int unsigned PEAK_IDX = 0;
`endif

    // A frame must hold the whole pulse plus at least one gap beat.
    function automatic int unsigned min_period(input int unsigned period,
                                               input int unsigned pulse_len);
        return (period < pulse_len + 1) ? pulse_len + 1 : period;
    endfunction

endpackage

// File: rtl/pulse_burst_tx.sv
// Framed AXI-stream pulse source: PULSE_LEN pulse beats, then an idle gap up to the period.
// PULSE_BURST_TX_RAMP_EN selects a shaped pulse with half-amplitude edge samples.
module pulse_burst_tx
    import pulse_burst_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned PULSE_LEN    = 4,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [DATA_WIDTH-1:0]   amp,
    input  logic [DATA_WIDTH-1:0]   idle_level,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic                    out_tlast,
    output logic                    peak_stb,
    output logic [CNT_WIDTH-1:0]    burst_count
);

    state_e                  state_q;
    logic [PERIOD_WIDTH-1:0] k_q;
    logic [PERIOD_WIDTH-1:0] p_eff_q;

    logic [PERIOD_WIDTH-1:0] p_new;
    logic [PERIOD_WIDTH-1:0] nxt_k;
    logic [PERIOD_WIDTH-1:0] nxt_p;
    logic [DATA_WIDTH-1:0]   nxt_data;
    logic                    nxt_last;
    logic                    nxt_peak;
    logic                    nxt_in_pulse;
    logic                    restart;
    logic                    hs;
    logic                    go_idle;
    logic                    load;

    always_comb begin
        p_new        = PERIOD_WIDTH'(min_period(32'(period), PULSE_LEN));
        hs           = out_tvalid && out_tready;
        // The next beat opens a frame when leaving idle or after the frame's last beat.
        restart      = (state_q == StIdle) || out_tlast;
        nxt_k        = restart ? '0 : k_q + PERIOD_WIDTH'(1);
        nxt_p        = restart ? p_new : p_eff_q;
        nxt_in_pulse = nxt_k < PERIOD_WIDTH'(PULSE_LEN);
        nxt_data     = idle_level;
        if (nxt_in_pulse) begin
`ifdef PULSE_BURST_TX_RAMP_EN
            if (nxt_k == '0 || nxt_k == PERIOD_WIDTH'(PULSE_LEN - 1)) begin
                nxt_data = amp >> 1;
            end else begin
                nxt_data = amp;
            end
`else
            nxt_data = amp;
`endif
        end
        nxt_last = (nxt_k == nxt_p - PERIOD_WIDTH'(1));
        nxt_peak = (nxt_k == PERIOD_WIDTH'(PEAK_IDX));
        go_idle  = hs && out_tlast && !enable;
        load     = (state_q == StIdle) ? enable : (hs && !go_idle);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= StIdle;
            k_q         <= '0;
            p_eff_q     <= '0;
            out_tvalid  <= 1'b0;
            out_tdata   <= '0;
            out_tlast   <= 1'b0;
            peak_stb    <= 1'b0;
            burst_count <= '0;
        end else begin
            if (hs && out_tlast) begin
                burst_count <= burst_count + CNT_WIDTH'(1);
            end
            if (load) begin
                state_q    <= nxt_in_pulse ? StPulse : StGap;
                k_q        <= nxt_k;
                p_eff_q    <= nxt_p;
                out_tvalid <= 1'b1;
                out_tdata  <= nxt_data;
                out_tlast  <= nxt_last;
                peak_stb   <= nxt_peak;
            end else if (go_idle) begin
                state_q    <= StIdle;
                k_q        <= '0;
                out_tvalid <= 1'b0;
                out_tdata  <= '0;
                out_tlast  <= 1'b0;
                peak_stb   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_burst_tx.sv
// Scoreboard bench for pulse_burst_tx; the expected pulse shape follows PULSE_BURST_TX_RAMP_EN.
module tb_pulse_burst_tx;

    localparam int DW = 16;
    localparam int PL = 4;
    localparam int PW = 16;
    localparam int CW = 16;
`ifdef PULSE_BURST_TX_RAMP_EN
    localparam int PEAK = 1;
`else
    localparam int PEAK = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] period = 16'd10;
    logic [DW-1:0] amp = 16'h4000;
    logic [DW-1:0] idle_level = 16'h0010;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b1;
    logic          out_tlast;
    logic          peak_stb;
    logic [CW-1:0] burst_count;

    pulse_burst_tx #(
        .DATA_WIDTH  (DW),
        .PULSE_LEN   (PL),
        .PERIOD_WIDTH(PW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .enable     (enable),
        .period     (period),
        .amp        (amp),
        .idle_level (idle_level),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .peak_stb   (peak_stb),
        .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          peak;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    pops = 0;
    int    exp_bursts = 0;
    bit    mon_en = 1'b0;
    bit    rand_ready = 1'b0;
    bit    stall_q = 1'b0;
    bit    cnt_chk = 1'b0;
    beat_t held;

    function automatic beat_t model_beat(input int k, input int peff, input logic [DW-1:0] a,
                                         input logic [DW-1:0] idl);
        beat_t b;
        if (k < PL) begin
`ifdef PULSE_BURST_TX_RAMP_EN
            b.data = (k == 0 || k == PL - 1) ? (a >> 1) : a;
`else
            b.data = a;
`endif
        end else begin
            b.data = idl;
        end
        b.last = (k == peff - 1);
        b.peak = (k == PEAK);
        return b;
    endfunction

    task automatic push_frame(input int p, input logic [DW-1:0] a, input logic [DW-1:0] idl);
        int peff;
        peff = (p < PL + 1) ? PL + 1 : p;
        for (int k = 0; k < peff; k++) exp_q.push_back(model_beat(k, peff, a, idl));
    endtask

    // Ready is re-driven just after each active edge.
    always begin
        @(posedge clk);
        #1;
        out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor: pops on accepted beats, checks holds during stalls.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cnt_chk) begin
                checks++;
                if (burst_count !== CW'(exp_bursts))
                    $display("FAIL burst_after_tlast: got %0d want %0d", burst_count, exp_bursts);
                else passed++;
                cnt_chk = 1'b0;
            end
            if (stall_q) begin
                checks++;
                if (out_tvalid !== 1'b1 || {out_tdata, out_tlast, peak_stb} !== held)
                    $display("FAIL stall_hold: got v=%b %h/%b/%b want v=1 %h/%b/%b", out_tvalid,
                             out_tdata, out_tlast, peak_stb, held.data, held.last, held.peak);
                else passed++;
            end
            if (out_tvalid && out_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat: got %h/%b/%b want none", out_tdata,
                             out_tlast, peak_stb);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if ({out_tdata, out_tlast, peak_stb} !== e)
                        $display("FAIL beat %0d: got %h/%b/%b want %h/%b/%b", pops, out_tdata,
                                 out_tlast, peak_stb, e.data, e.last, e.peak);
                    else passed++;
                    if (e.last) begin
                        exp_bursts++;
                        cnt_chk = 1'b1;
                    end
                end
                pops++;
            end
            stall_q = out_tvalid && !out_tready;
            held    = {out_tdata, out_tlast, peak_stb};
        end else begin
            stall_q = 1'b0;
            cnt_chk = 1'b0;
        end
    end

    task automatic wait_pops(input int target, output bit ok);
        int b = 0;
        while (pops < target && b < 3000) begin
            @(posedge clk);
            b++;
        end
        if (b > 0) #1;
        ok = (pops >= target);
    endtask

    task automatic wait_drain(output bit ok);
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(posedge clk);
            b++;
        end
        if (b > 0) #1;
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_tvalid, out_tdata, out_tlast, peak_stb, burst_count} !== '0)
            $display("FAIL reset_values: got v=%b d=%h l=%b p=%b c=%0d want all zero",
                     out_tvalid, out_tdata, out_tlast, peak_stb, burst_count);
        else passed++;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0) $display("FAIL idle_no_enable: got tvalid=%b want 0", out_tvalid);
        else passed++;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        int start = exp_bursts;
        period = 16'd10; amp = 16'h4000; idle_level = 16'h0010;
        push_frame(10, amp, idle_level);
        push_frame(10, amp, idle_level);
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0) $display("FAIL start_latency_early: got %b want 0", out_tvalid);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_tvalid !== 1'b1) $display("FAIL no_bubble[%0d]: got tvalid=%b want 1", i,
                                              out_tvalid);
            else passed++;
            if (i == 10) begin
                @(posedge clk);
                #1;
                enable = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0 || exp_q.size() != 0 || burst_count !== CW'(start + 2))
            $display("FAIL basic_end: got v=%b left=%0d cnt=%0d want v=0 left=0 cnt=%0d",
                     out_tvalid, exp_q.size(), burst_count, start + 2);
        else passed++;
    endtask

    task automatic test_min_period();
        int start = exp_bursts;
        int base = pops;
        bit ok1, ok2;
        period = 16'd2; amp = 16'h1234; idle_level = 16'hfff0;
        for (int f = 0; f < 3; f++) push_frame(2, amp, idle_level);
        enable = 1'b1;
        @(posedge clk);
        #1;
        wait_pops(base + 2 * (PL + 1), ok1);
        enable = 1'b0;
        wait_drain(ok2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok1 || !ok2 || out_tvalid !== 1'b0 || burst_count !== CW'(start + 3))
            $display("FAIL min_period: got ok=%b%b v=%b cnt=%0d want ok=11 v=0 cnt=%0d", ok1,
                     ok2, out_tvalid, burst_count, start + 3);
        else passed++;
    endtask

    task automatic test_backpressure();
        int start = exp_bursts;
        int base = pops;
        bit ok1, ok2;
        rand_ready = 1'b1;
        period = 16'd10; amp = 16'h7ffe; idle_level = 16'h0123;
        for (int f = 0; f < 3; f++) push_frame(10, amp, idle_level);
        enable = 1'b1;
        @(posedge clk);
        #1;
        wait_pops(base + 20, ok1);
        enable = 1'b0;
        wait_drain(ok2);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok1 || !ok2 || out_tvalid !== 1'b0 || burst_count !== CW'(start + 3))
            $display("FAIL backpressure: got ok=%b%b v=%b cnt=%0d want ok=11 v=0 cnt=%0d", ok1,
                     ok2, out_tvalid, burst_count, start + 3);
        else passed++;
    endtask

    task automatic test_enable_drop();
        int start = exp_bursts;
        int base = pops;
        bit ok1, ok2;
        period = 16'd10; amp = 16'h4000; idle_level = 16'h0010;
        push_frame(10, amp, idle_level);
        enable = 1'b1;
        @(posedge clk);
        #1;
        wait_pops(base + 3, ok1);
        enable = 1'b0;
        period = 16'd3;  // must not shorten the running frame
        wait_drain(ok2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok1 || !ok2 || out_tvalid !== 1'b0 || burst_count !== CW'(start + 1))
            $display("FAIL enable_drop: got ok=%b%b v=%b cnt=%0d want ok=11 v=0 cnt=%0d", ok1,
                     ok2, out_tvalid, burst_count, start + 1);
        else passed++;
    endtask

    task automatic test_clear();
        int base = pops;
        bit ok1, ok2, ok3;
        period = 16'd10; amp = 16'h4000; idle_level = 16'h0010;
        push_frame(10, amp, idle_level);
        enable = 1'b1;
        @(posedge clk);
        #1;
        wait_pops(base + 6, ok1);
        mon_en = 1'b0;
        clear  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok1 || {out_tvalid, out_tdata, out_tlast, peak_stb, burst_count} !== '0)
            $display("FAIL clear_values: got ok=%b v=%b d=%h l=%b p=%b c=%0d want ok=1 zeros",
                     ok1, out_tvalid, out_tdata, out_tlast, peak_stb, burst_count);
        else passed++;
        exp_q.delete();
        exp_bursts = 0;
        mon_en = 1'b1;
        base = pops;
        push_frame(10, amp, idle_level);
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        wait_pops(base + 1, ok2);
        enable = 1'b0;
        wait_drain(ok3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok2 || !ok3 || out_tvalid !== 1'b0 || burst_count !== CW'(1))
            $display("FAIL clear_restart: got ok=%b%b v=%b cnt=%0d want ok=11 v=0 cnt=1", ok2,
                     ok3, out_tvalid, burst_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_period();
        test_backpressure();
        test_enable_drop();
        test_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pulse_burst_tx.md
# pulse_burst_tx

Framed AXI-stream sample source that emits a periodic high-amplitude pulse followed by an idle gap. It is the transmit-side counterpart of the peak detector: it generates sync bursts with known peak positions and a matching peak strobe, so receive chains can be exercised and calibrated in-loop. It sits ahead of the DAC/loopback path in the dk_hdl utils.

## Interface
- DATA_WIDTH, 16, sample width
- PULSE_LEN, 4, pulse samples per frame (>= 3)
- PERIOD_WIDTH, 16, width of period input and frame counter
- CNT_WIDTH, 16, width of burst_count
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous soft reset, same effect as reset
- enable  in  1  level; start/continue framing
- period  in  PERIOD_WIDTH  samples per frame, P
- amp  in  DATA_WIDTH  pulse amplitude (unsigned)
- idle_level  in  DATA_WIDTH  gap sample value
- out_tdata  out  DATA_WIDTH  sample
- out_tvalid  out  1  sample valid
- out_tready  in  1  downstream ready
- out_tlast  out  1  last sample of frame
- peak_stb  out  1  high with the beat carrying the pulse peak
- burst_count  out  CNT_WIDTH  completed frames, wraps

## Operation
- States: IDLE, PULSE, GAP.
- IDLE: out_tvalid=0. When enable=1, latch P_eff = max(period, PULSE_LEN+1), load sample 0, go PULSE.
- Frame index k advances only on handshake (out_tvalid & out_tready).
- PULSE: k = 0..PULSE_LEN-1, out_tdata = amp. After beat k=PULSE_LEN-1 -> GAP.
- GAP: k = PULSE_LEN..P_eff-1, out_tdata = idle_level; out_tlast=1 at k=P_eff-1.
- On the tlast handshake: burst_count += 1 (modulo 2^CNT_WIDTH); if enable=1, re-latch period/P_eff and start a new frame (PULSE, k=0) with no bubble; else -> IDLE.
- Deassertion of enable mid-frame does not truncate; the frame completes.
- amp and idle_level are sampled when each beat is loaded; period is sampled only at frame start.
- peak_stb: high exactly while the peak beat is presented (k=0, no ramp); held with tdata during backpressure; qualified by out_tvalid.
- reset or clear at any point: all outputs to reset values next cycle, state IDLE, k=0; an in-flight frame is dropped without tlast.

## Timing
- Reset values: out_tvalid=0, out_tdata=0, out_tlast=0, peak_stb=0, burst_count=0.
- All outputs registered. enable rising in cycle n -> out_tvalid=1 with sample 0 in cycle n+1.
- With out_tready=1 throughout: one beat per cycle, frame length P_eff cycles, back-to-back frames.
- out_tvalid & !out_tready: out_tdata, out_tlast, peak_stb held stable; out_tvalid never drops until handshake (except reset/clear).
- burst_count updates the cycle after the tlast handshake.

## Configuration
- PULSE_BURST_TX_RAMP_EN defined: pulse is shaped; samples k=0 and k=PULSE_LEN-1 carry amp>>1, interior samples amp; peak_stb marks k=1.
- Undefined: rectangular pulse, all PULSE_LEN samples = amp; peak_stb marks k=0.
- Frame length, tlast and burst_count identical in both builds.

## Structure
- Package pulse_burst_tx_pkg: state enum (IDLE/PULSE/GAP), PEAK_IDX constant (0 or 1 by macro), min-period helper function.
- Single module; no sub-module needed. Output stage is the registered beat holder inside the FSM.

## Test plan
- Defaults, period=10, amp=0x4000, idle=0x0010, tready=1, enable held: beats 0-3 = 0x4000, 4-9 = 0x0010, tlast on beat 9, peak_stb on beat 0 only, burst_count=1 after cycle 10, next frame starts immediately.
- period=2 (below minimum): frames of 5 beats, tlast every 5th beat.
- Random tready (50%): data/tlast/peak_stb stable while stalled; beat sequence identical to tready=1 run.
- Drop enable at beat 3 of frame: frame finishes through beat 9 with tlast, then tvalid=0; burst_count increments once.
- Assert clear at beat 6: next cycle tvalid=0, burst_count=0; re-enable restarts at beat 0.
- Ramp build, amp=0x4000: pulse beats 0x2000, 0x4000, 0x4000, 0x2000; peak_stb on beat 1.
